// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the pipeline's multi-cycle data memory.
// Used by dmem_array and dmem_responder.
package mips_mem_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] LOAD_ERR_DATA = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } dmem_state_t;

    // Byte address to word index; the caller truncates to its own depth.
    function automatic logic [WORD_W-1:0] word_index(input logic [WORD_W-1:0] byte_addr);
        return {2'b00, byte_addr[WORD_W-1:2]};
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM: synchronous write, synchronous (registered) read, no reset.
module dmem_array
    import mips_mem_pkg::*;
#(
    parameter  int DEPTH_WORDS = 256,
    localparam int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the MEM stage: stalls the pipeline until ack.
// Optional DMEM_RANGE_CHECK_EN adds an err output and suppresses out-of-range accesses.
module dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        ack,
    output logic        busy
`ifdef DMEM_RANGE_CHECK_EN
    ,
    output logic        err
`endif
);

    localparam int ADDR_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    dmem_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [WORD_W-1:0] read_data_q, read_data_d;
    logic              is_rd_q, is_rd_d;
    logic              is_wr_q, is_wr_d;
    logic              ok_q, ok_d;
    logic              ack_q, ack_d;
    logic              busy_q, busy_d;

    logic              req;
    logic              access;
    logic              in_range;
    logic              arr_we;
    logic [ADDR_W-1:0] arr_addr;
    logic [WORD_W-1:0] arr_rdata;

`ifdef DMEM_RANGE_CHECK_EN
    logic err_q, err_d;
    assign in_range = ((address >> (ADDR_W + 2)) == '0);
`else
    assign in_range = 1'b1;
`endif

    assign req    = mem_read | mem_write;
    assign access = (state_q == WAIT) && (cnt_q == '0);
    assign arr_we = access & is_wr_q & ok_q;
    // The array reads every cycle; in IDLE it is pointed at the incoming address so
    // the word is already in its output register by the first WAIT cycle.
    assign arr_addr = (state_q == IDLE) ? ADDR_W'(word_index(address)) : idx_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        is_rd_d     = is_rd_q;
        is_wr_d     = is_wr_q;
        ok_d        = ok_q;
        read_data_d = read_data_q;
        ack_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = WAIT;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    idx_d   = ADDR_W'(word_index(address));
                    wdata_d = write_data;
                    is_rd_d = mem_read;
                    is_wr_d = mem_write;
                    ok_d    = in_range;
                end
            end
            WAIT: begin
                if (access) begin
                    state_d = DONE;
                    ack_d   = 1'b1;
                    if (is_rd_q) begin
                        if (!ok_q) begin
                            read_data_d = LOAD_ERR_DATA;
                        end else if (is_wr_q) begin
                            read_data_d = wdata_q;
                        end else begin
                            read_data_d = arr_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

`ifdef DMEM_RANGE_CHECK_EN
    assign err_d = access & ~ok_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            wdata_q     <= '0;
            is_rd_q     <= 1'b0;
            is_wr_q     <= 1'b0;
            ok_q        <= 1'b1;
            read_data_q <= '0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            is_rd_q     <= is_rd_d;
            is_wr_q     <= is_wr_d;
            ok_q        <= ok_d;
            read_data_q <= read_data_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
`ifdef DMEM_RANGE_CHECK_EN
            err_q       <= err_d;
`endif
        end
    end

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk  (clk),
        .we   (arr_we),
        .addr (arr_addr),
        .wdata(wdata_q),
        .rdata(arr_rdata)
    );

    // Stall drops in DONE so the pipeline advances on the ack cycle.
    assign stall     = ((state_q == IDLE) & req) | (state_q == WAIT);
    assign read_data = read_data_q;
    assign ack       = ack_q;
    assign busy      = busy_q;
`ifdef DMEM_RANGE_CHECK_EN
    assign err       = err_q;
`endif

endmodule
